move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/tetris_pkg.sv | 54 +++++
 rtl/key_repeat.sv | 77 +++++++
 rtl/move_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_move_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-block game: command opcodes, default
// timing constants (in milliseconds / tick1k strobes), pend bit positions,
// the scheduler state type and the gravity period helper.
package tetris_pkg;

  // Command opcodes offered to the game core
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_DOWN  = 3'd3;
  localparam logic [2:0] OP_ROT   = 3'd4;
  localparam logic [2:0] OP_GRAV  = 3'd5;

  // Default timing constants
  localparam int unsigned DAS_MS_DEF       = 170;
  localparam int unsigned ARR_MS_DEF       = 50;
  localparam int unsigned GRAV_BASE_MS_DEF = 1000;
  localparam int unsigned GRAV_STEP_MS_DEF = 90;
  localparam int unsigned GRAV_MIN_MS_DEF  = 100;

  // Bit positions inside pend = {GRAV, ROT, DOWN, RIGHT, LEFT}
  localparam int PB_LEFT  = 0;
  localparam int PB_RIGHT = 1;
  localparam int PB_DOWN  = 2;
  localparam int PB_ROT   = 3;
  localparam int PB_GRAV  = 4;

  // Width of the per-key hold counter (counts tick1k strobes)
  localparam int HCW = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_t;

  // Gravity period = max(base - level*step, min), level saturated at 9.
  // The clamp is decided before subtracting so the 11-bit result never wraps.
  function automatic logic [10:0] grav_period(input logic [3:0]  lvl,
                                              input logic [10:0] base,
                                              input logic [10:0] step,
                                              input logic [10:0] min_p);
    logic [10:0] l_eff;
    logic [10:0] prod;
    l_eff = (lvl > 4'd9) ? 11'd9 : {7'd0, lvl};
    prod  = l_eff * step;
    if (base <= min_p)
      grav_period = min_p;
    else if (prod >= (base - min_p))
      grav_period = min_p;
    else
      grav_period = base - prod;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Per-key edge detector with DAS/ARR auto-repeat.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_tick       1 kHz strobe
//   i_key        debounced key level (active-high)
//   i_rpt_en     enables auto-repeat while the key is held
//   i_halt       game over: suppresses output and holds the counter at 0
//   o_set        registered one-clk pulse requesting the key's pend bit
// A key that is already high out of reset is not armed until it has been
// seen low once, so holding a key through reset produces neither an edge
// nor auto-repeat.
module key_repeat
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_MS = DAS_MS_DEF,
  parameter int unsigned ARR_MS = ARR_MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_key,
  input  logic i_rpt_en,
  input  logic i_halt,
  output logic o_set
);

  localparam logic [HCW-1:0] DAS_L = HCW'(DAS_MS);
  localparam logic [HCW-1:0] ARR_L = HCW'(ARR_MS);

  logic           r_prev;
  logic           r_armed;
  logic           r_das_done;
  logic           r_set;
  logic [HCW-1:0] r_cnt;

  logic           w_edge;
  logic           w_held;
  logic           w_fire;
  logic [HCW-1:0] w_cnt_inc;

  assign w_edge    = i_key & ~r_prev & r_armed;
  // Held means high on this and the previous sample; the press clk itself
  // does not count towards the hold time.
  assign w_held    = i_key & r_prev & r_armed;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_fire    = i_rpt_en & w_held & i_tick &
                     (r_das_done ? (w_cnt_inc == ARR_L) : (w_cnt_inc == DAS_L));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev     <= 1'b0;
      r_armed    <= 1'b0;
      r_das_done <= 1'b0;
      r_cnt      <= '0;
      r_set      <= 1'b0;
    end else begin
      r_prev <= i_key;
      if (!i_key)
        r_armed <= 1'b1;
      if (i_halt || !w_held) begin
        r_cnt      <= '0;
        r_das_done <= 1'b0;
      end else if (i_tick && i_rpt_en) begin
        if (w_fire) begin
          r_cnt      <= '0;
          r_das_done <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
      r_set <= ~i_halt & (w_edge | w_fire);
    end
  end

  assign o_set = r_set;

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: turns key edges, key auto-repeat and gravity into a
// serial stream of commands for the game core.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   tick1k                     1 kHz strobe
//   k_left/k_right/k_down/k_rot debounced key levels
//   level [3:0]                speed level (saturated at 9)
//   game_over                  halts scheduling, clears pend and counters
//   cmd_valid, cmd_op [2:0]    registered command offer
//   cmd_ready                  core acceptance
//   pend [4:0]                 registered pending bits {GRAV,ROT,DOWN,RIGHT,LEFT}
//   o_dbg_state                current FSM state (0 IDLE, 1 ISSUE)
// Handshake: a command transfers on a clk where cmd_valid and cmd_ready are
// both high; while cmd_valid is high and cmd_ready low, cmd_op is held
// stable; after a transfer cmd_valid drops for at least one clk.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_MS       = DAS_MS_DEF,
  parameter int unsigned ARR_MS       = ARR_MS_DEF,
  parameter int unsigned GRAV_BASE_MS = GRAV_BASE_MS_DEF,
  parameter int unsigned GRAV_STEP_MS = GRAV_STEP_MS_DEF,
  parameter int unsigned GRAV_MIN_MS  = GRAV_MIN_MS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick1k,
  input  logic       k_left,
  input  logic       k_right,
  input  logic       k_down,
  input  logic       k_rot,
  input  logic [3:0] level,
  input  logic       game_over,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ready,
  output logic [4:0] pend,
  output logic       o_dbg_state
);

  localparam logic [10:0] GB = 11'(GRAV_BASE_MS);
  localparam logic [10:0] GS = 11'(GRAV_STEP_MS);
  localparam logic [10:0] GM = 11'(GRAV_MIN_MS);

  sched_state_t r_state;
  sched_state_t w_state_nx;
  logic         r_cmd_valid;
  logic         w_valid_nx;
  logic [2:0]   r_cmd_op;
  logic [2:0]   w_op_nx;
  logic [4:0]   r_pend;
  logic [4:0]   w_clr;
  logic [4:0]   w_pend_set;
  logic         w_down_acc;

  logic         w_set_left;
  logic         w_set_right;
  logic         w_set_down;
  logic         w_set_rot;

  logic [10:0]  r_gcnt;
  logic [10:0]  w_gcnt_inc;
  logic [10:0]  w_gper;
  logic         w_grav_fire;

  // ---------------- key edge / repeat units ----------------
  key_repeat #(.DAS_MS(DAS_MS), .ARR_MS(ARR_MS)) u_kr_left (
    .clk(clk), .rst_n(rst_n), .i_tick(tick1k), .i_key(k_left),
    .i_rpt_en(1'b1), .i_halt(game_over), .o_set(w_set_left)
  );

  key_repeat #(.DAS_MS(DAS_MS), .ARR_MS(ARR_MS)) u_kr_right (
    .clk(clk), .rst_n(rst_n), .i_tick(tick1k), .i_key(k_right),
    .i_rpt_en(1'b1), .i_halt(game_over), .o_set(w_set_right)
  );

  key_repeat #(.DAS_MS(DAS_MS), .ARR_MS(ARR_MS)) u_kr_down (
    .clk(clk), .rst_n(rst_n), .i_tick(tick1k), .i_key(k_down),
    .i_rpt_en(1'b1), .i_halt(game_over), .o_set(w_set_down)
  );

  key_repeat #(.DAS_MS(DAS_MS), .ARR_MS(ARR_MS)) u_kr_rot (
    .clk(clk), .rst_n(rst_n), .i_tick(tick1k), .i_key(k_rot),
    .i_rpt_en(1'b0), .i_halt(game_over), .o_set(w_set_rot)
  );

  // ---------------- gravity divider ----------------
  assign w_gper      = grav_period(level, GB, GS, GM);
  assign w_gcnt_inc  = r_gcnt + 11'd1;
  // ">=" lets a level change that lands below the current count fire on the
  // very next strobe instead of waiting for a wrap.
  assign w_grav_fire = tick1k & ~game_over & (w_gcnt_inc >= w_gper);

  always_ff @(posedge clk) begin
    if (!rst_n || game_over)
      r_gcnt <= '0;
    else if (w_down_acc)
      r_gcnt <= '0;
    else if (tick1k)
      r_gcnt <= w_grav_fire ? 11'd0 : w_gcnt_inc;
  end

  // ---------------- pend register ----------------
  always_comb begin
    w_pend_set           = '0;
    w_pend_set[PB_LEFT]  = w_set_left;
    w_pend_set[PB_RIGHT] = w_set_right;
    w_pend_set[PB_DOWN]  = w_set_down;
    w_pend_set[PB_ROT]   = w_set_rot;
    w_pend_set[PB_GRAV]  = w_grav_fire;
  end

  // Set is applied after clear so a same-clk set wins.
  always_ff @(posedge clk) begin
    if (!rst_n || game_over)
      r_pend <= '0;
    else
      r_pend <= (r_pend & ~w_clr) | w_pend_set;
  end

  // ---------------- arbiter + FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NONE;
    end else begin
      r_state     <= w_state_nx;
      r_cmd_valid <= w_valid_nx;
      r_cmd_op    <= w_op_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_cmd_valid;
    w_op_nx    = r_cmd_op;
    w_clr      = '0;
    w_down_acc = 1'b0;
    if (game_over) begin
      w_state_nx = ST_IDLE;
      w_valid_nx = 1'b0;
      w_op_nx    = OP_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_valid_nx = 1'b0;
          w_op_nx    = OP_NONE;
          if (r_pend != 5'd0) begin
            w_state_nx = ST_ISSUE;
            w_valid_nx = 1'b1;
            // Priority ROT > LEFT > RIGHT > DOWN > GRAV
            if (r_pend[PB_ROT]) begin
              w_op_nx       = OP_ROT;
              w_clr[PB_ROT] = 1'b1;
            end else if (r_pend[PB_LEFT]) begin
              w_op_nx        = OP_LEFT;
              w_clr[PB_LEFT] = 1'b1;
            end else if (r_pend[PB_RIGHT]) begin
              w_op_nx         = OP_RIGHT;
              w_clr[PB_RIGHT] = 1'b1;
            end else if (r_pend[PB_DOWN]) begin
              w_op_nx        = OP_DOWN;
              w_clr[PB_DOWN] = 1'b1;
            end else begin
              w_op_nx        = OP_GRAV;
              w_clr[PB_GRAV] = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            w_state_nx = ST_IDLE;
            w_valid_nx = 1'b0;
            w_op_nx    = OP_NONE;
            // A soft drop replaces the pending gravity step.
            if (r_cmd_op == OP_DOWN) begin
              w_down_acc     = 1'b1;
              w_clr[PB_GRAV] = 1'b1;
            end
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_valid_nx = 1'b0;
          w_op_nx    = OP_NONE;
        end
      endcase
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_op      = r_cmd_op;
  assign pend        = r_pend;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with shortened timing constants.
module tb_move_scheduler;
  import tetris_pkg::*;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       tick1k    = 1'b0;
  logic       k_left    = 1'b0;
  logic       k_right   = 1'b0;
  logic       k_down    = 1'b0;
  logic       k_rot     = 1'b0;
  logic [3:0] level     = 4'd0;
  logic       game_over = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [4:0] pend;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic tick_en  = 1'b0;
  int   tdiv     = 0;
  int   tick_abs = 0;

  // Accepted-command log (written only by the monitor) and expectations
  logic [2:0] got_op_q[$];
  int         got_tick_q[$];
  int         got_cyc_q[$];
  logic [2:0] exp_q[$];
  int         exp_tick_q[$];
  int         rd = 0;

  move_scheduler #(
    .DAS_MS(3), .ARR_MS(2), .GRAV_BASE_MS(20), .GRAV_STEP_MS(5), .GRAV_MIN_MS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick1k(tick1k),
    .k_left(k_left), .k_right(k_right), .k_down(k_down), .k_rot(k_rot),
    .level(level), .game_over(game_over),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .pend(pend), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // tick1k: one clk high every 10 clk while enabled, phase restarts on enable
  always @(negedge clk) begin
    if (tick_en) begin
      if (tdiv == 9) begin
        tdiv     = 0;
        tick1k   = 1'b1;
        tick_abs = tick_abs + 1;
      end else begin
        tdiv   = tdiv + 1;
        tick1k = 1'b0;
      end
    end else begin
      tdiv   = 0;
      tick1k = 1'b0;
    end
  end

  // Monitor: log every handshake
  always @(posedge clk) begin
    if (rst_n && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      got_op_q.push_back(cmd_op);
      got_tick_q.push_back(tick_abs);
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(cmd_valid), 32'd1);
  endtask

  task automatic wait_ticks(input string tag, input int t0, input int k);
    int n = 0;
    while ((tick_abs - t0) < k && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 32'((tick_abs - t0) >= k), 32'd1);
  endtask

  // Compare the commands logged since the last call against exp_q;
  // an expected tick of -1 means the tick stamp is not checked.
  task automatic check_log(input string tag, input int t0);
    chk({tag, "_count"}, 32'(got_op_q.size() - rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd + i < got_op_q.size()) begin
        chk($sformatf("%s_op%0d", tag, i), 32'(got_op_q[rd + i]), 32'(exp_q[i]));
        if (exp_tick_q[i] >= 0)
          chk($sformatf("%s_tick%0d", tag, i), 32'(got_tick_q[rd + i] - t0), 32'(exp_tick_q[i]));
      end
    end
    rd = got_op_q.size();
    exp_q.delete();
    exp_tick_q.delete();
  endtask

  task automatic expect_cmd(input logic [2:0] op, input int tk);
    exp_q.push_back(op);
    exp_tick_q.push_back(tk);
  endtask

  // Pulse game_over to clear pend and all counters between scenarios
  task automatic clear_state();
    k_left    = 1'b0;
    k_right   = 1'b0;
    k_down    = 1'b0;
    k_rot     = 1'b0;
    tick_en   = 1'b0;
    cmd_ready = 1'b1;
    game_over = 1'b1;
    repeat (3) step();
    game_over = 1'b0;
    repeat (3) step();
    rd = got_op_q.size();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int c0;

    // Reset
    rst_n = 1'b0;
    at_pos();
    at_pos();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_op", 32'(cmd_op), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;

    // Scenario 1: k_left edge sampled at clk 100
    while (cyc < 99) step();
    k_left = 1'b1;
    at_pos();                      // clk 100
    step();
    k_left = 1'b0;
    at_pos();                      // clk 101
    chk("s1_valid_101", 32'(cmd_valid), 32'd0);
    chk("s1_pend_101", 32'(pend), 32'h01);
    at_pos();                      // clk 102
    chk("s1_valid_102", 32'(cmd_valid), 32'd1);
    chk("s1_op_102", 32'(cmd_op), 32'(OP_LEFT));
    at_pos();                      // clk 103, accepted at this edge
    chk("s1_valid_103", 32'(cmd_valid), 32'd0);
    chk("s1_op_idle", 32'(cmd_op), 32'(OP_NONE));
    chk("s1_state_idle", 32'(dbg_state), 32'd0);
    repeat (10) step();
    expect_cmd(OP_LEFT, -1);
    check_log("s1", 0);

    // Scenario 2a: k_right held for 10 ticks
    clear_state();
    t0      = tick_abs;
    k_right = 1'b1;
    tick_en = 1'b1;
    wait_ticks("s2r_wait", t0, 10);
    repeat (5) step();
    k_right = 1'b0;
    tick_en = 1'b0;
    repeat (10) step();
    expect_cmd(OP_RIGHT, 0);
    expect_cmd(OP_RIGHT, 3);
    expect_cmd(OP_RIGHT, 5);
    expect_cmd(OP_RIGHT, 7);
    expect_cmd(OP_RIGHT, 9);
    check_log("s2r", t0);

    // Scenario 2b: k_rot held for 10 ticks, no repeat
    clear_state();
    t0      = tick_abs;
    k_rot   = 1'b1;
    tick_en = 1'b1;
    wait_ticks("s2o_wait", t0, 10);
    repeat (5) step();
    k_rot   = 1'b0;
    tick_en = 1'b0;
    repeat (10) step();
    expect_cmd(OP_ROT, 0);
    check_log("s2o", t0);

    // Scenario 3: three keys together with the core stalled
    clear_state();
    cmd_ready = 1'b0;
    k_left    = 1'b1;
    k_rot     = 1'b1;
    k_down    = 1'b1;
    step();
    wait_valid("s3_valid");
    chk("s3_op_first", 32'(cmd_op), 32'(OP_ROT));
    chk("s3_pend_stall", 32'(pend), 32'h05);
    k_left = 1'b0;
    k_rot  = 1'b0;
    k_down = 1'b0;
    for (int i = 0; i < 50; i++) begin
      at_pos();
      chk("s3_stall_valid", 32'(cmd_valid), 32'd1);
      chk("s3_stall_op", 32'(cmd_op), 32'(OP_ROT));
    end
    step();
    cmd_ready = 1'b1;
    repeat (12) step();
    c0 = rd;
    if (got_cyc_q.size() >= c0 + 3) begin
      chk("s3_gap1", 32'(got_cyc_q[c0 + 1] - got_cyc_q[c0]), 32'd2);
      chk("s3_gap2", 32'(got_cyc_q[c0 + 2] - got_cyc_q[c0 + 1]), 32'd2);
    end
    expect_cmd(OP_ROT, -1);
    expect_cmd(OP_LEFT, -1);
    expect_cmd(OP_DOWN, -1);
    check_log("s3", 0);

    // Scenario 4a: level 0 gravity every 20 ticks
    clear_state();
    level   = 4'd0;
    t0      = tick_abs;
    tick_en = 1'b1;
    wait_ticks("s4a_wait", t0, 40);
    repeat (8) step();
    tick_en = 1'b0;
    expect_cmd(OP_GRAV, 20);
    expect_cmd(OP_GRAV, 40);
    check_log("s4a", t0);

    // Scenario 4b: level 9 clamps to 4 ticks
    level = 4'd9;
    clear_state();
    t0      = tick_abs;
    tick_en = 1'b1;
    wait_ticks("s4b_wait", t0, 8);
    repeat (8) step();
    tick_en = 1'b0;
    expect_cmd(OP_GRAV, 4);
    expect_cmd(OP_GRAV, 8);
    check_log("s4b", t0);

    // Scenario 4c: DOWN at tick 15 restarts the gravity period
    level = 4'd0;
    clear_state();
    t0      = tick_abs;
    tick_en = 1'b1;
    wait_ticks("s4c_wait15", t0, 15);
    repeat (2) step();
    k_down = 1'b1;
    repeat (2) step();
    k_down = 1'b0;
    wait_ticks("s4c_wait35", t0, 35);
    repeat (8) step();
    tick_en = 1'b0;
    expect_cmd(OP_DOWN, 15);
    expect_cmd(OP_GRAV, 35);
    check_log("s4c", t0);

    // Scenario 5: game_over during a stalled handshake
    clear_state();
    cmd_ready = 1'b0;
    k_left    = 1'b1;
    k_right   = 1'b1;
    step();
    wait_valid("s5_valid");
    chk("s5_op", 32'(cmd_op), 32'(OP_LEFT));
    chk("s5_pend", 32'(pend), 32'h02);
    game_over = 1'b1;
    at_pos();
    chk("s5_go_valid", 32'(cmd_valid), 32'd0);
    chk("s5_go_pend", 32'(pend), 32'd0);
    chk("s5_go_state", 32'(dbg_state), 32'd0);
    cmd_ready = 1'b1;
    tick_en   = 1'b1;
    step();
    k_left  = 1'b0;
    k_right = 1'b0;
    repeat (3) step();
    k_rot = 1'b1;
    repeat (3) step();
    k_rot = 1'b0;
    repeat (3) step();
    k_down = 1'b1;
    repeat (30) step();
    k_down = 1'b0;
    step();
    chk("s5_hold_valid", 32'(cmd_valid), 32'd0);
    game_over = 1'b0;
    tick_en   = 1'b0;
    repeat (20) step();
    check_log("s5", 0);

    // Scenario 6: reset mid-ISSUE with k_down held
    clear_state();
    cmd_ready = 1'b0;
    k_down    = 1'b1;
    step();
    wait_valid("s6_valid");
    chk("s6_op", 32'(cmd_op), 32'(OP_DOWN));
    rst_n = 1'b0;
    at_pos();
    chk("s6_rst_valid", 32'(cmd_valid), 32'd0);
    chk("s6_rst_op", 32'(cmd_op), 32'd0);
    chk("s6_rst_pend", 32'(pend), 32'd0);
    chk("s6_rst_state", 32'(dbg_state), 32'd0);
    step();
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    t0        = tick_abs;
    tick_en   = 1'b1;
    wait_ticks("s6_hold", t0, 6);
    repeat (3) step();
    check_log("s6_held", t0);
    k_down = 1'b0;
    repeat (2) step();
    k_down = 1'b1;
    repeat (3) step();
    k_down  = 1'b0;
    tick_en = 1'b0;
    repeat (8) step();
    expect_cmd(OP_DOWN, -1);
    check_log("s6_repress", t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
